// File: rtl/fifo_sync.sv
// Synchronous FIFO with registered read data, registered status flags and
// sticky overflow/underflow reporting. Single clock domain.
module fifo_sync #(
  parameter int FIFO_WIDTH = 8,
  parameter int ADDR_WIDTH = 5,
  parameter int AF_LEVEL   = 28,
  parameter int AE_LEVEL   = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  w_ena,
  input  logic [FIFO_WIDTH-1:0] w_data,
  input  logic                  r_ena,
  output logic [FIFO_WIDTH-1:0] r_data,
  output logic                  r_valid,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  overflow,
  output logic                  underflow,
  input  logic                  clr_err
);

  localparam int CW    = ADDR_WIDTH + 1;
  localparam int DEPTH = 2 ** ADDR_WIDTH;

  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] AF_C    = CW'(AF_LEVEL);
  localparam logic [CW-1:0] AE_C    = CW'(AE_LEVEL);
  localparam logic [CW-1:0] ONE_C   = CW'(1);

  logic [FIFO_WIDTH-1:0] mem [DEPTH];

  logic [CW-1:0] wr_ptr;
  logic [CW-1:0] rd_ptr;
  logic [CW-1:0] count_nxt;
  logic          push_ok;
  logic          pop_ok;
  logic          overflow_nxt;
  logic          underflow_nxt;

  // Acceptance looks only at the registered flags, so a full FIFO rejects a
  // push even when a pop in the same cycle would have made room.
  assign push_ok = w_ena & ~full;
  assign pop_ok  = r_ena & ~empty;

  always_comb begin
    count_nxt = count;
    unique case ({push_ok, pop_ok})
      2'b10:   count_nxt = count + ONE_C;
      2'b01:   count_nxt = count - ONE_C;
      default: count_nxt = count;
    endcase
  end

  // Set has priority over clear.
  always_comb begin
    overflow_nxt  = overflow;
    underflow_nxt = underflow;
    if (clr_err) begin
      overflow_nxt  = 1'b0;
      underflow_nxt = 1'b0;
    end
    if (w_ena & full) begin
      overflow_nxt = 1'b1;
    end
    if (r_ena & empty) begin
      underflow_nxt = 1'b1;
    end
  end

  // Storage carries no reset.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr[ADDR_WIDTH-1:0]] <= w_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      r_data       <= '0;
      r_valid      <= 1'b0;
      full         <= 1'b0;
      empty        <= 1'b1;
      almost_full  <= 1'b0;
      almost_empty <= 1'b1;
      overflow     <= 1'b0;
      underflow    <= 1'b0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + ONE_C;
      end
      if (pop_ok) begin
        r_data <= mem[rd_ptr[ADDR_WIDTH-1:0]];
        rd_ptr <= rd_ptr + ONE_C;
      end
      r_valid      <= pop_ok;
      count        <= count_nxt;
      full         <= (count_nxt == DEPTH_C);
      empty        <= (count_nxt == '0);
      almost_full  <= (count_nxt >= AF_C);
      almost_empty <= (count_nxt <= AE_C);
      overflow     <= overflow_nxt;
      underflow    <= underflow_nxt;
    end
  end

endmodule

// File: tb/tb_fifo_sync.sv
// Directed bench for fifo_sync: a behavioural queue model supplies expected
// data and flags, checked one time unit after every rising edge.
module tb_fifo_sync;

  localparam int W = 8;
  localparam int A = 5;
  localparam int D = 32;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         w_ena = 1'b0;
  logic [W-1:0] w_data = '0;
  logic         r_ena = 1'b0;
  logic         clr_err = 1'b0;
  logic [W-1:0] r_data;
  logic         r_valid;
  logic         full;
  logic         empty;
  logic         almost_full;
  logic         almost_empty;
  logic [A:0]   count;
  logic         overflow;
  logic         underflow;

  fifo_sync #(.FIFO_WIDTH(W), .ADDR_WIDTH(A), .AF_LEVEL(28), .AE_LEVEL(4)) dut (
    .clk(clk), .rst(rst), .w_ena(w_ena), .w_data(w_data), .r_ena(r_ena),
    .r_data(r_data), .r_valid(r_valid), .full(full), .empty(empty),
    .almost_full(almost_full), .almost_empty(almost_empty), .count(count),
    .overflow(overflow), .underflow(underflow), .clr_err(clr_err)
  );

  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  logic [W-1:0] sb[$];
  int           m_count = 0;
  bit           m_ov = 0;
  bit           m_un = 0;
  bit           m_valid = 0;
  logic [W-1:0] m_rdata = '0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_state(input string tag);
    check({tag, ".count"}, 32'(count), 32'(m_count));
    check({tag, ".full"}, 32'(full), 32'(m_count == D));
    check({tag, ".empty"}, 32'(empty), 32'(m_count == 0));
    check({tag, ".almost_full"}, 32'(almost_full), 32'(m_count >= 28));
    check({tag, ".almost_empty"}, 32'(almost_empty), 32'(m_count <= 4));
    check({tag, ".overflow"}, 32'(overflow), 32'(m_ov));
    check({tag, ".underflow"}, 32'(underflow), 32'(m_un));
    check({tag, ".r_valid"}, 32'(r_valid), 32'(m_valid));
    if (r_valid === 1'b1) begin
      if (sb.size() == 0) begin
        check({tag, ".spurious_pop"}, 32'(r_data), 32'hFFFF_FFFF);
      end else begin
        m_rdata = sb.pop_front();
        check({tag, ".r_data"}, 32'(r_data), 32'(m_rdata));
      end
    end else begin
      check({tag, ".r_data_hold"}, 32'(r_data), 32'(m_rdata));
    end
  endtask

  task automatic model_reset();
    sb.delete();
    m_count = 0;
    m_ov    = 0;
    m_un    = 0;
    m_valid = 0;
    m_rdata = '0;
  endtask

  // One clock cycle: drive at negedge, model the edge, check after it.
  task automatic op(input string tag, input bit w, input logic [W-1:0] d,
                    input bit r, input bit clr);
    bit m_full, m_empty, push, pop;
    @(negedge clk);
    w_ena = w; w_data = d; r_ena = r; clr_err = clr;
    m_full  = (m_count == D);
    m_empty = (m_count == 0);
    push = w & ~m_full;
    pop  = r & ~m_empty;
    if (clr) begin m_ov = 0; m_un = 0; end
    if (w & m_full) m_ov = 1;
    if (r & m_empty) m_un = 1;
    if (push) begin sb.push_back(d); m_count++; end
    if (pop) m_count--;
    m_valid = pop;
    @(posedge clk);
    #1;
    check_state(tag);
    @(negedge clk);
    w_ena = 0; r_ena = 0; clr_err = 0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, ".r_data"}, 32'(r_data), 32'h0);
    check({tag, ".r_valid"}, 32'(r_valid), 32'h0);
    check({tag, ".full"}, 32'(full), 32'h0);
    check({tag, ".empty"}, 32'(empty), 32'h1);
    check({tag, ".almost_full"}, 32'(almost_full), 32'h0);
    check({tag, ".almost_empty"}, 32'(almost_empty), 32'h1);
    check({tag, ".count"}, 32'(count), 32'h0);
    check({tag, ".overflow"}, 32'(overflow), 32'h0);
    check({tag, ".underflow"}, 32'(underflow), 32'h0);
  endtask

  initial begin
    #12;
    check_reset_outputs("reset");
    @(negedge clk);
    rst = 0;

    // Fill 0x00..0x1F, then drain in order.
    for (int i = 0; i < D; i++) op("fill", 1, W'(i), 0, 0);
    for (int i = 0; i < D; i++) op("drain", 0, '0, 1, 0);

    // Overflow, clear, and set-beats-clear.
    for (int i = 0; i < D; i++) op("fill2", 1, W'(8'h40 + i), 0, 0);
    op("push_full", 1, 8'hAA, 0, 0);
    op("clr_ov", 0, '0, 0, 1);
    op("set_wins", 1, 8'hAB, 0, 1);
    for (int i = 0; i < D; i++) op("drain2", 0, '0, 1, 0);
    op("clr2", 0, '0, 0, 1);

    // Underflow; push-and-pop while empty.
    op("pop_empty", 0, '0, 1, 0);
    op("wr_rd_empty", 1, 8'h5A, 1, 0);
    op("clr3", 0, '0, 0, 1);

    // Steady state at 16 words across pointer wrap.
    for (int i = 0; i < 15; i++) op("to16", 1, W'(8'h80 + i), 0, 0);
    for (int i = 0; i < 100; i++) op("stream", 1, W'(i * 3 + 1), 1, 0);

    // Push and pop together while full.
    while (m_count < D) op("fill3", 1, W'(8'hC0 + m_count), 0, 0);
    op("wr_rd_full", 1, 8'hEE, 1, 0);
    check("wr_rd_full.count31", 32'(count), 32'd31);
    check("wr_rd_full.overflow", 32'(overflow), 32'h1);
    while (m_count > 0) op("drain3", 0, '0, 1, 0);
    op("clr4", 0, '0, 0, 1);

    // Asynchronous reset between edges.
    for (int i = 0; i < 10; i++) op("pre_rst", 1, W'(8'h10 + i), 0, 0);
    op("pre_rst_pop", 0, '0, 1, 0);
    #2;
    rst = 1;
    #1;
    check_reset_outputs("async_rst");
    model_reset();
    @(negedge clk);
    rst = 0;
    op("post_rst_pop", 0, '0, 1, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
